// File: rtl/reg_file32_pkg.sv
// Shared constants for the 32 x 32 register file feeding the ALU operand ports.
package reg_file32_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/reg_file32_word.sv
// One register-file word: async active-low clear, loads i_d when i_we is high.
module reg_word
  import reg_file32_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_we,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_file32.sv
// Register file: two combinational read ports, one synchronous write port,
// r0 hardwired to zero, optional same-cycle write-to-read bypass.
module reg_file32 #(
  parameter int DATA_W = reg_file32_pkg::DATA_W,
  parameter int ADDR_W = reg_file32_pkg::ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);
  import reg_file32_pkg::*;

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;

  logic [DATA_W-1:0] w_regs [NREG];
  logic [NREG-1:0]   w_wr_onehot;
  logic              w_wr_live;
  logic              w_bypass_a;
  logic              w_bypass_b;

  // Decoder bit 0 is forced low so r0 can never be written.
  always_comb begin
    w_wr_onehot = '0;
    if (wr_en) begin
      w_wr_onehot[wr_addr] = 1'b1;
    end
    w_wr_onehot[0] = 1'b0;
  end

  assign w_regs[0] = '0;

  for (genvar g = 1; g < NREG; g++) begin : g_word
    reg_word #(.W(DATA_W)) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .i_we  (w_wr_onehot[g]),
      .i_d   (wr_data),
      .o_q   (w_regs[g])
    );
  end

  // Bypass is gated by rst_n so reads stay zero for the whole reset window.
  assign w_wr_live  = (BYPASS != 0) && rst_n && wr_en && (wr_addr != ADDR_ZERO);
  assign w_bypass_a = w_wr_live && (rd_addr_a == wr_addr);
  assign w_bypass_b = w_wr_live && (rd_addr_b == wr_addr);

  assign rd_data_a = w_bypass_a ? wr_data : w_regs[rd_addr_a];
  assign rd_data_b = w_bypass_b ? wr_data : w_regs[rd_addr_b];

endmodule

// File: tb/tb_reg_file32.sv
// Directed bench for reg_file32: checks a bypassing and a non-bypassing
// instance against a bench-side register model.
module tb_reg_file32;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [31:0] nb_data_a;
  logic [31:0] nb_data_b;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  logic [31:0] model [32];
  logic [31:0] exp_q [$];
  int checks;
  int errors;

  reg_file32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  reg_file32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (nb_data_a),
    .rd_data_b (nb_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: one write cycle, inputs changed 1 ns after the rising edge.
  task automatic write(input logic [4:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (addr != 5'd0) model[addr] = data;
  endtask

  // Scoreboard: expected values come from the model through exp_q.
  task automatic read_check(input string tag, input logic [4:0] a, input logic [4:0] b);
    logic [31:0] ea;
    logic [31:0] eb;
    rd_addr_a = a;
    rd_addr_b = b;
    exp_q.push_back(model[a]);
    exp_q.push_back(model[b]);
    #1;
    ea = exp_q.pop_front();
    eb = exp_q.pop_front();
    check({tag, "_a"}, rd_data_a, ea);
    check({tag, "_b"}, rd_data_b, eb);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // 1: reads all zero while reset is held
    #2;
    for (int i = 0; i < 32; i++) read_check("reset_read", 5'(i), 5'(31 - i));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 2: r5 / r6 and ALU NOR of the operands
    write(5'd5, 32'hFFFF_FFFF);
    write(5'd6, 32'h0000_0000);
    read_check("r5_r6", 5'd5, 5'd6);
    check("nor_r5_r6", ~(rd_data_a | rd_data_b), 32'h0000_0000);

    // 3: writes to r0 are discarded
    write(5'd0, 32'hDEAD_BEEF);
    read_check("r0_write", 5'd0, 5'd0);

    // 4: same-cycle bypass vs stored value, r0 never bypassed
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678;
    rd_addr_a = 5'd7; rd_addr_b = 5'd5;
    #1;
    check("bypass_on", rd_data_a, 32'h1234_5678);
    check("bypass_off", nb_data_a, 32'h0000_0000);
    check("bypass_other_port", rd_data_b, 32'hFFFF_FFFF);
    wr_addr = 5'd0; wr_data = 32'hCAFE_0000; rd_addr_a = 5'd0;
    #1;
    check("bypass_r0", rd_data_a, 32'h0000_0000);
    wr_addr = 5'd7; wr_data = 32'h1234_5678; rd_addr_a = 5'd7;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    model[7] = 32'h1234_5678;
    check("after_edge_nb", nb_data_a, 32'h1234_5678);
    read_check("after_edge", 5'd7, 5'd7);

    // 5: both ports on the same address
    write(5'd9, 32'hA5A5_A5A5);
    read_check("same_addr", 5'd9, 5'd9);

    // wr_en low: no state change
    wr_addr = 5'd10; wr_data = 32'hFFFF_0000;
    @(posedge clk);
    #1;
    read_check("wr_en_low", 5'd10, 5'd9);

    // 6: fill r1..r31, then reset mid-cycle with a write pending
    for (int i = 1; i < 32; i++) write(5'(i), 32'h0101_0101 * i);
    check("fill_r31_model", model[31], 32'h1F1F_1F1F);
    for (int i = 0; i < 32; i++) read_check("fill_read", 5'(i), 5'(31 - i));
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE_F00D;
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    #1;
    rd_addr_a = 5'd3; rd_addr_b = 5'd31;
    #1;
    check("reset_now_a", rd_data_a, 32'h0000_0000);
    check("reset_now_b", rd_data_b, 32'h0000_0000);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) read_check("post_reset", 5'(i), 5'(i));
    @(negedge clk);
    rst_n = 1'b1;
    read_check("write_lost", 5'd3, 5'd1);

    // first write after reset release takes effect on the first edge
    write(5'd4, 32'h55AA_55AA);
    read_check("first_write", 5'd4, 5'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
